rv32i_regfile: RTL and testbench

RV32I integer register file: 32 x 32-bit registers, one write-back port, two combinational read ports. It is the responder for the write-back/read-select interface (wb_enable, wb_reg, wb_data, rs1_reg, rs2_reg) that the core and the board-level test harness drive. It includes a post-reset clearing sequencer so that every register reads zero before the core starts issuing. It also includes same-cycle write-to-read bypass.

---
 rtl/rv32i_regfile_if.sv | 23 ++
 rtl/rv32i_regfile.sv | 87 ++++++++
 tb/tb_rv32i_regfile.sv | 134 +++++++++++++
 3 files changed

// File: rtl/rv32i_regfile_if.sv
// Write-back / read-select bus between the core (master) and the register file (slave).
interface rv32i_regfile_if #(
  parameter int XLEN = 32
);
  logic            wb_enable;
  logic [4:0]      wb_reg;
  logic [XLEN-1:0] wb_data;
  logic [4:0]      rs1_reg;
  logic [4:0]      rs2_reg;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            ready;

  modport master (
    output wb_enable, wb_reg, wb_data, rs1_reg, rs2_reg,
    input  rs1_data, rs2_data, ready
  );

  modport slave (
    input  wb_enable, wb_reg, wb_data, rs1_reg, rs2_reg,
    output rs1_data, rs2_data, ready
  );
endinterface

// File: rtl/rv32i_regfile.sv
// RV32I integer register file: one write port, two combinational read ports with
// same-cycle write bypass, and a post-reset sweep that zeroes x1..x(NREGS-1).
module rv32i_regfile #(
  parameter int XLEN           = 32,
  parameter int NREGS          = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  rv32i_regfile_if.slave  rf
);
  localparam int         NPORTS = 2;
  localparam logic [4:0] LAST   = 5'(NREGS - 1);
  localparam logic [5:0] NR     = 6'(NREGS);

  typedef enum logic {INIT, RUN} state_t;

  state_t          state;
  logic [4:0]      clr_idx;
  logic            ready_q;
  logic            active;
  logic [XLEN-1:0] regs [NREGS];

  logic            we;
  logic [4:0]      wa;
  logic [XLEN-1:0] wd;

  logic [NPORTS-1:0][4:0]      rd_idx;
  logic [NPORTS-1:0][XLEN-1:0] rd_data;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= INIT;
      clr_idx <= 5'd1;
      ready_q <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          if (!CLEAR_ON_RESET || clr_idx == LAST) begin
            state   <= RUN;
            ready_q <= 1'b1;
          end
          clr_idx <= clr_idx + 5'd1;
        end
        default: ready_q <= 1'b1;
      endcase
    end
  end

  // Single physical write port shared by the clearing sweep and core write-back.
  always_comb begin
    we = 1'b0;
    wa = rf.wb_reg;
    wd = rf.wb_data;
    if (reset) begin
      if (state == INIT) begin
        we = CLEAR_ON_RESET;
        wa = clr_idx;
        wd = '0;
      end else if (rf.wb_enable && rf.wb_reg != 5'd0) begin
        we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we && wa != 5'd0 && {1'b0, wa} < NR) regs[wa] <= wd;
  end

  // Gating with reset keeps outputs quiet during the reset-low cycle itself.
  assign active   = ready_q & reset;
  assign rf.ready = active;
  assign rd_idx   = {rf.rs2_reg, rf.rs1_reg};

  for (genvar p = 0; p < NPORTS; p++) begin : g_rd
    always_comb begin
      rd_data[p] = '0;
      if (active && rd_idx[p] != 5'd0) begin
        if (rf.wb_enable && rf.wb_reg == rd_idx[p]) rd_data[p] = rf.wb_data;
        else if ({1'b0, rd_idx[p]} < NR)             rd_data[p] = regs[rd_idx[p]];
      end
    end
  end

  assign rf.rs1_data = rd_data[0];
  assign rf.rs2_data = rd_data[1];
endmodule

// File: tb/tb_rv32i_regfile.sv
// Scoreboard bench: stimulus pushes expected read-port/ready values, a negedge monitor compares.
module tb_rv32i_regfile;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  rv32i_regfile_if #(.XLEN(32)) bus ();

  rv32i_regfile #(.XLEN(32), .NREGS(32), .CLEAR_ON_RESET(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .rf    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] r1;
    logic [31:0] r2;
    logic        rdy;
  } exp_t;

  exp_t sb [$];

  task automatic cmp(input string name, input string field, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got 0x%08h expected 0x%08h", name, field, act, exp);
    end
  endtask

  // Monitor: consumes every expectation queued for the current cycle.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      cmp(e.name, "rs1_data", bus.rs1_data, e.r1);
      cmp(e.name, "rs2_data", bus.rs2_data, e.r2);
      cmp(e.name, "ready", {31'd0, bus.ready}, {31'd0, e.rdy});
    end
  end

  task automatic push(input string name, input logic [31:0] r1, input logic [31:0] r2,
                      input logic rdy);
    exp_t e;
    e.name = name; e.r1 = r1; e.r2 = r2; e.rdy = rdy;
    sb.push_back(e);
  endtask

  task automatic drive(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2);
    bus.wb_enable = we;
    bus.wb_reg    = wr;
    bus.wb_data   = wd;
    bus.rs1_reg   = r1;
    bus.rs2_reg   = r2;
  endtask

  task automatic step(input string name, input logic we, input logic [4:0] wr,
                      input logic [31:0] wd, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [31:0] e1, input logic [31:0] e2);
    drive(we, wr, wd, r1, r2);
    push(name, e1, e2, 1'b1);
    @(posedge clk);
    #1;
  endtask

  // Cycles 0..30 after reset release must all show ready low and zeroed reads.
  task automatic sweep(input string name, input logic inject, input logic [4:0] r1,
                       input logic [4:0] r2);
    for (int k = 0; k < 31; k++) begin
      if (inject && k == 9) drive(1'b1, 5'd7, 32'hDEADBEEF, r1, r2);
      else                  drive(1'b0, 5'd0, 32'd0, r1, r2);
      push(name, 32'd0, 32'd0, 1'b0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    drive(1'b1, 5'd5, 32'h1234, 5'd5, 5'd31);
    push("reset_low", 32'd0, 32'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    sweep("init_sweep", 1'b1, 5'd7, 5'd31);

    step("post_ready",  1'b0, 5'd0,  32'd0,        5'd5,  5'd31, 32'd0,        32'd0);
    step("init_write",  1'b0, 5'd0,  32'd0,        5'd7,  5'd31, 32'd0,        32'd0);
    step("bypass",      1'b1, 5'd10, 32'h25,       5'd10, 5'd15, 32'h25,       32'd0);
    step("x10_stored",  1'b0, 5'd0,  32'd0,        5'd10, 5'd15, 32'h25,       32'd0);
    step("x0_write",    1'b1, 5'd0,  32'd321,      5'd0,  5'd10, 32'd0,        32'h25);
    step("x0_after",    1'b0, 5'd0,  32'd0,        5'd0,  5'd10, 32'd0,        32'h25);
    step("dual_bypass", 1'b1, 5'd5,  32'h20,       5'd5,  5'd5,  32'h20,       32'h20);
    step("dual_stored", 1'b0, 5'd0,  32'd0,        5'd5,  5'd5,  32'h20,       32'h20);
    step("x31_full",    1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd5,  32'hFFFFFFFF, 32'h20);
    step("bypass_rs1",  1'b1, 5'd10, 32'hAAAA5555, 5'd10, 5'd31, 32'hAAAA5555, 32'hFFFFFFFF);
    step("x10_new",     1'b1, 5'd10, 32'h25,       5'd31, 5'd10, 32'hFFFFFFFF, 32'h25);
    step("x10_restore", 1'b0, 5'd0,  32'd0,        5'd10, 5'd5,  32'h25,       32'h20);

    // Reset mid-run with a simultaneous write: reset wins, sweep restarts.
    reset = 1'b0;
    drive(1'b1, 5'd3, 32'h77, 5'd10, 5'd3);
    push("reset_mid", 32'd0, 32'd0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    sweep("mid_sweep", 1'b0, 5'd10, 5'd3);
    step("mid_cleared", 1'b0, 5'd0,  32'd0,        5'd10, 5'd3,  32'd0,        32'd0);
    step("mid_x31",     1'b0, 5'd0,  32'd0,        5'd31, 5'd5,  32'd0,        32'd0);
    step("mid_write",   1'b1, 5'd3,  32'h0BADF00D, 5'd10, 5'd3,  32'd0,        32'h0BADF00D);
    step("mid_readbk",  1'b0, 5'd0,  32'd0,        5'd3,  5'd0,  32'h0BADF00D, 32'd0);

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
